// File: rtl/branch_predictor_if.sv
`default_nettype none
// ============================================================================
//  Module   : branch_predictor_if
//  Purpose  : Bundles the fetch-side prediction lookup and the EX-side
//             resolution/update signals of the branch predictor.
//  Ports    : fetch   - pcF in; predtakenF, predtargetF, predidxF out
//             resolve - upd_* and clear in; mispredictE, redirect_pc out
//             stats   - br_cnt, mp_cnt out
//  Modports : master = pipeline side, slave = predictor side
//  Revision : 1.0 - initial release
// ============================================================================
interface branch_predictor_if #(
  parameter int ADDR_W  = 32,
  parameter int ENTRIES = 16
);
  localparam int IDX_W = $clog2(ENTRIES);

  // Fetch lookup
  logic [ADDR_W-1:0] pcF;
  logic              predtakenF;
  logic [ADDR_W-1:0] predtargetF;
  logic [IDX_W-1:0]  predidxF;

  // Resolution / update from EX
  logic              upd_valid;
  logic [ADDR_W-1:0] upd_pc;
  logic [IDX_W-1:0]  upd_idx;
  logic              upd_taken;
  logic              upd_jump;
  logic [ADDR_W-1:0] upd_target;
  logic              upd_predtaken;
  logic [ADDR_W-1:0] upd_predtarget;
  logic              clear;
  logic              mispredictE;
  logic [ADDR_W-1:0] redirect_pc;

  // Statistics
  logic [31:0]       br_cnt;
  logic [31:0]       mp_cnt;

  modport master (
    output pcF, upd_valid, upd_pc, upd_idx, upd_taken, upd_jump,
           upd_target, upd_predtaken, upd_predtarget, clear,
    input  predtakenF, predtargetF, predidxF, mispredictE, redirect_pc,
           br_cnt, mp_cnt
  );

  modport slave (
    input  pcF, upd_valid, upd_pc, upd_idx, upd_taken, upd_jump,
           upd_target, upd_predtaken, upd_predtarget, clear,
    output predtakenF, predtargetF, predidxF, mispredictE, redirect_pc,
           br_cnt, mp_cnt
  );
endinterface
`default_nettype wire

// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
//  Module   : branch_predictor
//  Purpose  : Bimodal (MODE=0) or gshare (MODE=1) branch predictor with a
//             direct-mapped tagged BTB, 2-bit saturating counters and
//             resolved-branch / mispredict statistics.
//  Ports    : clk   - clock, rising edge
//             reset - asynchronous, active-low
//             bp    - branch_predictor_if.slave (fetch, update, stats)
//  Revision : 1.0 - initial release
// ============================================================================
module branch_predictor #(
  parameter int ADDR_W  = 32,
  parameter int ENTRIES = 16,
  parameter int MODE    = 0,
  parameter int GHR_W   = 4
) (
  input  wire logic         clk,
  input  wire logic         reset,
  branch_predictor_if.slave bp
);
  localparam int                IDX_W       = $clog2(ENTRIES);
  localparam int                TAG_W       = ADDR_W - 2 - IDX_W;
  localparam logic [1:0]        C_CNT_INIT  = 2'b01;
  localparam logic [1:0]        C_CNT_MAX   = 2'b11;
  localparam logic [1:0]        C_CNT_MIN   = 2'b00;
  localparam logic [ADDR_W-1:0] C_WORD_MASK = ~ADDR_W'(3);
  localparam logic [ADDR_W-1:0] C_PC_STEP   = ADDR_W'(4);

  // Table state
  logic [1:0]        cnt_q    [ENTRIES];
  logic [1:0]        cnt_d    [ENTRIES];
  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  logic [TAG_W-1:0]  tag_d    [ENTRIES];
  logic [ADDR_W-1:0] target_q [ENTRIES];
  logic [ADDR_W-1:0] target_d [ENTRIES];
  logic [31:0]       br_cnt_q, br_cnt_d;
  logic [31:0]       mp_cnt_q, mp_cnt_d;

  logic [IDX_W-1:0]  w_ghr_idx;

  // Low two PC bits never influence lookup, tags or fall-through targets.
  logic [ADDR_W-1:0] w_pc_f_word, w_pc_u_word;
  logic [IDX_W-1:0]  w_bidx, w_pidx, w_u_bidx;
  logic [TAG_W-1:0]  w_f_tag, w_u_tag;
  logic              w_f_hit, w_mispredict;

  // --------------------------------------------------------------------------
  // Fetch lookup: purely combinational from current state, so a same-cycle
  // update is not visible until after the edge.
  // --------------------------------------------------------------------------
  assign w_pc_f_word = bp.pcF & C_WORD_MASK;
  assign w_bidx      = w_pc_f_word[IDX_W+1:2];
  assign w_f_tag     = w_pc_f_word[ADDR_W-1:IDX_W+2];
  assign w_pidx      = w_bidx ^ w_ghr_idx;
  assign w_f_hit     = valid_q[w_bidx] && (tag_q[w_bidx] == w_f_tag) && cnt_q[w_pidx][1];

  assign bp.predtakenF  = w_f_hit;
  assign bp.predtargetF = w_f_hit ? target_q[w_bidx] : w_pc_f_word + C_PC_STEP;
  assign bp.predidxF    = w_pidx;

  // --------------------------------------------------------------------------
  // Resolution
  // --------------------------------------------------------------------------
  assign w_pc_u_word  = bp.upd_pc & C_WORD_MASK;
  assign w_u_bidx     = w_pc_u_word[IDX_W+1:2];
  assign w_u_tag      = w_pc_u_word[ADDR_W-1:IDX_W+2];
  assign w_mispredict = bp.upd_valid &&
                        ((bp.upd_taken != bp.upd_predtaken) ||
                         (bp.upd_taken && (bp.upd_target != bp.upd_predtarget)));

  assign bp.mispredictE = w_mispredict;
  assign bp.redirect_pc = bp.upd_taken ? bp.upd_target : w_pc_u_word + C_PC_STEP;
  assign bp.br_cnt      = br_cnt_q;
  assign bp.mp_cnt      = mp_cnt_q;

  // --------------------------------------------------------------------------
  // Global history: only exists in gshare mode, folded into the counter index.
  // --------------------------------------------------------------------------
  generate
    if (MODE == 1) begin : g_gshare
      logic [GHR_W-1:0] ghr_q, ghr_d;

      always_comb begin
        ghr_d = ghr_q;
        if (bp.clear) begin
          ghr_d = '0;
        end else if (bp.upd_valid) begin
          // Shift in the resolved outcome; the oldest bit falls off the top.
          ghr_d = GHR_W'({ghr_q, bp.upd_taken});
        end
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) ghr_q <= '0;
        else        ghr_q <= ghr_d;
      end

      assign w_ghr_idx = IDX_W'(ghr_q);
    end else begin : g_bimodal
      assign w_ghr_idx = '0;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Table next state. Clear wins over an update, but statistics still count.
  // --------------------------------------------------------------------------
  always_comb begin
    cnt_d    = cnt_q;
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    br_cnt_d = br_cnt_q + {31'd0, bp.upd_valid};
    mp_cnt_d = mp_cnt_q + {31'd0, w_mispredict};

    if (bp.clear) begin
      valid_d = '0;
      for (int i = 0; i < ENTRIES; i++) cnt_d[i] = C_CNT_INIT;
    end else if (bp.upd_valid) begin
      if (bp.upd_jump) begin
        cnt_d[bp.upd_idx] = C_CNT_MAX;
      end else if (bp.upd_taken) begin
        if (cnt_q[bp.upd_idx] != C_CNT_MAX) cnt_d[bp.upd_idx] = cnt_q[bp.upd_idx] + 2'd1;
      end else begin
        if (cnt_q[bp.upd_idx] != C_CNT_MIN) cnt_d[bp.upd_idx] = cnt_q[bp.upd_idx] - 2'd1;
      end

      // Only taken outcomes allocate; the new tag simply evicts any alias.
      if (bp.upd_taken) begin
        valid_d[w_u_bidx]  = 1'b1;
        tag_d[w_u_bidx]    = w_u_tag;
        target_d[w_u_bidx] = bp.upd_target;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q  <= '0;
      br_cnt_q <= '0;
      mp_cnt_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        cnt_q[i]    <= C_CNT_INIT;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
      end
    end else begin
      valid_q  <= valid_d;
      br_cnt_q <= br_cnt_d;
      mp_cnt_q <= mp_cnt_d;
      cnt_q    <= cnt_d;
      tag_q    <= tag_d;
      target_q <= target_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_branch_predictor
//  Purpose  : Self-checking bench for branch_predictor. Drives one bimodal
//             and one gshare instance with identical stimulus and compares
//             both against a behavioural table model every cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_branch_predictor;
  localparam int ADDR_W  = 32;
  localparam int ENTRIES = 16;
  localparam int GHR_W   = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  branch_predictor_if #(.ADDR_W(ADDR_W), .ENTRIES(ENTRIES)) bp0 ();
  branch_predictor_if #(.ADDR_W(ADDR_W), .ENTRIES(ENTRIES)) bp1 ();

  branch_predictor #(.ADDR_W(ADDR_W), .ENTRIES(ENTRIES), .MODE(0), .GHR_W(GHR_W)) u_dut0 (
    .clk(clk), .reset(rst_n), .bp(bp0));
  branch_predictor #(.ADDR_W(ADDR_W), .ENTRIES(ENTRIES), .MODE(1), .GHR_W(GHR_W)) u_dut1 (
    .clk(clk), .reset(rst_n), .bp(bp1));

  // Shared stimulus
  logic [31:0] s_pc = '0, s_upc = '0, s_tgt = '0, s_ptgt = '0;
  logic [3:0]  s_uidx = '0;
  logic        s_uv = 1'b0, s_tk = 1'b0, s_jmp = 1'b0, s_ptk = 1'b0, s_clr = 1'b0;

  assign bp0.pcF = s_pc;            assign bp1.pcF = s_pc;
  assign bp0.upd_valid = s_uv;      assign bp1.upd_valid = s_uv;
  assign bp0.upd_pc = s_upc;        assign bp1.upd_pc = s_upc;
  assign bp0.upd_idx = s_uidx;      assign bp1.upd_idx = s_uidx;
  assign bp0.upd_taken = s_tk;      assign bp1.upd_taken = s_tk;
  assign bp0.upd_jump = s_jmp;      assign bp1.upd_jump = s_jmp;
  assign bp0.upd_target = s_tgt;    assign bp1.upd_target = s_tgt;
  assign bp0.upd_predtaken = s_ptk; assign bp1.upd_predtaken = s_ptk;
  assign bp0.upd_predtarget = s_ptgt; assign bp1.upd_predtarget = s_ptgt;
  assign bp0.clear = s_clr;         assign bp1.clear = s_clr;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Behavioural model: plain arrays indexed by word address arithmetic.
  // --------------------------------------------------------------------------
  int unsigned m_cnt [ENTRIES];
  bit          m_val [ENTRIES];
  bit [31:0]   m_tag [ENTRIES];
  bit [31:0]   m_tgt [ENTRIES];
  int unsigned m_ghr;
  bit [31:0]   m_br, m_mp;

  function automatic bit [31:0] next_word(input bit [31:0] pc);
    return (pc & 32'hFFFF_FFFC) + 32'd4;
  endfunction
  function automatic int unsigned slot(input bit [31:0] pc);
    return (pc / 4) % ENTRIES;
  endfunction
  function automatic int unsigned pidx(input bit [31:0] pc, input int mode);
    return (mode == 1) ? (slot(pc) ^ m_ghr) : slot(pc);
  endfunction
  function automatic bit ptaken(input bit [31:0] pc, input int mode);
    return m_val[slot(pc)] && (m_tag[slot(pc)] == pc / (4 * ENTRIES)) && (m_cnt[pidx(pc, mode)] >= 2);
  endfunction
  function automatic bit [31:0] ptarget(input bit [31:0] pc, input int mode);
    return ptaken(pc, mode) ? m_tgt[slot(pc)] : next_word(pc);
  endfunction
  function automatic bit exp_mispred();
    return s_uv && ((s_tk != s_ptk) || (s_tk && (s_tgt != s_ptgt)));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_cnt[i] = 1; m_val[i] = 0; m_tag[i] = '0; m_tgt[i] = '0;
    end
    m_ghr = 0; m_br = '0; m_mp = '0;
  endtask

  task automatic model_update();
    if (s_uv) m_br = m_br + 1;
    if (exp_mispred()) m_mp = m_mp + 1;
    if (s_clr) begin
      for (int i = 0; i < ENTRIES; i++) begin m_cnt[i] = 1; m_val[i] = 0; end
      m_ghr = 0;
    end else if (s_uv) begin
      if (s_jmp)                         m_cnt[s_uidx] = 3;
      else if (s_tk && m_cnt[s_uidx] < 3)  m_cnt[s_uidx] = m_cnt[s_uidx] + 1;
      else if (!s_tk && m_cnt[s_uidx] > 0) m_cnt[s_uidx] = m_cnt[s_uidx] - 1;
      if (s_tk) begin
        m_val[slot(s_upc)] = 1;
        m_tag[slot(s_upc)] = s_upc / (4 * ENTRIES);
        m_tgt[slot(s_upc)] = s_tgt;
      end
      m_ghr = ((m_ghr * 2) + (s_tk ? 1 : 0)) % (1 << GHR_W);
    end
  endtask

  task automatic check_set(input string tag, input int mode, input logic pt, input logic [31:0] ptg,
                           input logic [3:0] pi, input logic mp, input logic [31:0] rd,
                           input logic [31:0] bc, input logic [31:0] mc);
    chk({tag, ".predtakenF"},  {31'd0, pt}, {31'd0, ptaken(s_pc, mode)});
    chk({tag, ".predtargetF"}, ptg, ptarget(s_pc, mode));
    chk({tag, ".predidxF"},    {28'd0, pi}, pidx(s_pc, mode));
    chk({tag, ".mispredictE"}, {31'd0, mp}, {31'd0, exp_mispred()});
    chk({tag, ".redirect_pc"}, rd, s_tk ? s_tgt : next_word(s_upc));
    chk({tag, ".br_cnt"},      bc, m_br);
    chk({tag, ".mp_cnt"},      mc, m_mp);
  endtask

  // Compare process: check late in the low phase, advance the model at the edge.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (!rst_n) model_reset();
      check_set("mode0", 0, bp0.predtakenF, bp0.predtargetF, bp0.predidxF, bp0.mispredictE,
                bp0.redirect_pc, bp0.br_cnt, bp0.mp_cnt);
      check_set("mode1", 1, bp1.predtakenF, bp1.predtargetF, bp1.predidxF, bp1.mispredictE,
                bp1.redirect_pc, bp1.br_cnt, bp1.mp_cnt);
      @(posedge clk);
      if (!rst_n) model_reset();
      else        model_update();
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic drive(input bit [31:0] pc, input bit uv, input bit [31:0] upc, input bit [3:0] uidx,
                       input bit tk, input bit jmp, input bit [31:0] tgt, input bit ptk,
                       input bit [31:0] ptgt, input bit clr);
    @(negedge clk);
    #1;
    s_pc = pc; s_uv = uv; s_upc = upc; s_uidx = uidx; s_tk = tk; s_jmp = jmp;
    s_tgt = tgt; s_ptk = ptk; s_ptgt = ptgt; s_clr = clr;
  endtask
  task automatic idle(input bit [31:0] pc);
    drive(pc, 0, '0, '0, 0, 0, '0, 0, '0, 0);
  endtask
  task automatic upd(input bit [31:0] upc, input bit tk, input bit [31:0] tgt, input bit ptk,
                     input bit [31:0] ptgt);
    drive(32'h0, 1, upc, 4'(slot(upc)), tk, 0, tgt, ptk, ptgt, 0);
  endtask
  function automatic bit [31:0] rand_pc();
    bit [31:0] hi;
    hi = ($urandom_range(9) == 0) ? 32'hFFFF_FFC0 : (32'($urandom_range(3)) << 6);
    return hi | (32'($urandom_range(15)) << 2) | 32'($urandom_range(3));
  endfunction

  initial begin
    bit [31:0] upc;
    bit        tk;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    idle(32'h100);
    #1;
    chk("lit_reset_predtaken", {31'd0, bp0.predtakenF}, 32'd0);
    chk("lit_reset_predtarget", bp0.predtargetF, 32'h104);
    chk("lit_reset_br_cnt", bp0.br_cnt, 32'd0);
    idle(32'hFFFF_FFFC);
    #1 chk("lit_wrap_predtarget", bp0.predtargetF, 32'h0);

    // Two taken updates train counter 0 and allocate the BTB entry
    upd(32'h100, 1, 32'h80, 0, 32'h0);
    #1;
    chk("lit_first_mispredictE", {31'd0, bp0.mispredictE}, 32'd1);
    chk("lit_first_redirect", bp0.redirect_pc, 32'h80);
    upd(32'h100, 1, 32'h80, 0, 32'h0);
    idle(32'h100);
    #1;
    chk("lit_trained_predtaken", {31'd0, bp0.predtakenF}, 32'd1);
    chk("lit_trained_predtarget", bp0.predtargetF, 32'h80);
    chk("lit_trained_mp_cnt", bp0.mp_cnt, 32'd2);
    chk("lit_trained_br_cnt", bp0.br_cnt, 32'd2);

    // Decay from strongly taken, then saturate at zero
    upd(32'h100, 0, 32'h0, 1, 32'h80);
    idle(32'h100);
    #1 chk("lit_nt1_predtaken", {31'd0, bp0.predtakenF}, 32'd1);
    upd(32'h100, 0, 32'h0, 1, 32'h80);
    idle(32'h100);
    #1 chk("lit_nt2_predtaken", {31'd0, bp0.predtakenF}, 32'd0);
    upd(32'h100, 0, 32'h0, 0, 32'h0);
    upd(32'h100, 1, 32'h80, 0, 32'h0);
    idle(32'h100);
    #1 chk("lit_sat0_predtaken", {31'd0, bp0.predtakenF}, 32'd0);

    // Alias 0x140 onto slot 0: evicts the 0x100 tag
    upd(32'h140, 1, 32'hC0, 0, 32'h0);
    idle(32'h100);
    #1 chk("lit_alias_miss", {31'd0, bp0.predtakenF}, 32'd0);
    idle(32'h140);
    #1 chk("lit_alias_target", bp0.predtargetF, 32'hC0);

    // gshare history T,T,N -> 0110
    drive(32'h0, 0, '0, '0, 0, 0, '0, 0, '0, 1);
    upd(32'h100, 1, 32'h80, 1, 32'h80);
    upd(32'h100, 1, 32'h80, 1, 32'h80);
    upd(32'h100, 0, 32'h0, 1, 32'h80);
    idle(32'h100);
    #1;
    chk("lit_gshare_predidx", {28'd0, bp1.predidxF}, 32'h6);
    chk("lit_bimodal_predidx", {28'd0, bp0.predidxF}, 32'h0);

    // Clear with a concurrent taken update: table effects dropped, still counted
    drive(32'h0, 1, 32'h100, 4'h0, 1, 0, 32'h80, 0, 32'h0, 1);
    idle(32'h100);
    #1;
    chk("lit_clear_predtaken", {31'd0, bp0.predtakenF}, 32'd0);
    chk("lit_clear_br_cnt", bp0.br_cnt, 32'd11);

    // Reset in the middle of an update overrides it
    upd(32'h100, 1, 32'h80, 0, 32'h0);
    upd(32'h100, 1, 32'h80, 0, 32'h0);
    idle(32'h100);
    #1 chk("lit_pre_reset_predtaken", {31'd0, bp0.predtakenF}, 32'd1);
    upd(32'h100, 1, 32'h80, 0, 32'h0);
    rst_n = 1'b0;
    idle(32'h100);
    rst_n = 1'b1;
    #1;
    chk("lit_post_reset_predtaken", {31'd0, bp0.predtakenF}, 32'd0);
    chk("lit_post_reset_predtarget", bp0.predtargetF, 32'h104);
    chk("lit_post_reset_br_cnt", bp0.br_cnt, 32'd0);
    chk("lit_post_reset_mp_cnt", bp0.mp_cnt, 32'd0);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      upc = rand_pc();
      tk  = 1'($urandom_range(1));
      if ($urandom_range(9) < 6) begin
        bit jmp;
        jmp = ($urandom_range(9) == 0);
        drive(rand_pc(), 1, upc,
              ($urandom_range(1) == 0) ? 4'(pidx(upc, 0)) : 4'($urandom_range(15)),
              tk | jmp, jmp,
              ($urandom_range(1) == 0) ? 32'($urandom_range(3)) << 6 : $urandom,
              ($urandom_range(9) < 7) ? ptaken(upc, 0) : 1'($urandom_range(1)),
              ($urandom_range(9) < 7) ? ptarget(upc, 0) : $urandom,
              ($urandom_range(29) == 0));
      end else begin
        drive(rand_pc(), 0, upc, 4'($urandom_range(15)), tk, 0, $urandom, 0, $urandom,
              ($urandom_range(29) == 0));
      end
      rst_n = ($urandom_range(149) != 0);
    end
    idle(32'h0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, the PC width.
REQ-002 SHALL have parameter ENTRIES, default 16, the number of table entries; it must be a power of 2 and at least 4.
REQ-003 SHALL have parameter MODE, default 0; 0 selects bimodal, 1 selects gshare.
REQ-004 SHALL have parameter GHR_W, default 4, the global history width; it is used only when MODE=1, and GHR_W <= log2(ENTRIES).
REQ-005 Ports; IDX_W = log2(ENTRIES), TAG_W = ADDR_W-2-IDX_W:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- pcF  in  ADDR_W  fetch PC.
- predtakenF  out  1  prediction: taken.
- predtargetF  out  ADDR_W  predicted target.
- predidxF  out  IDX_W  counter index used; the pipeline carries it to EX.
- upd_valid  in  1  a branch or jump resolved in EX this cycle.
- upd_pc  in  ADDR_W  PC of the resolved instruction.
- upd_idx  in  IDX_W  predidxF value carried with that instruction.
- upd_taken  in  1  actual outcome.
- upd_jump  in  1  instruction is jal/jalr.
- upd_target  in  ADDR_W  actual target.
- upd_predtaken  in  1  prediction carried from F.
- upd_predtarget  in  ADDR_W  predicted target carried from F.
- clear  in  1  synchronous table invalidate.
- mispredictE  out  1  redirect required.
- redirect_pc  out  ADDR_W  correct next PC.
- br_cnt  out  32  resolved-branch count.
- mp_cnt  out  32  mispredict count.

Function
REQ-006 State SHALL consist of:
- ENTRIES 2-bit saturating counters, cnt[].
- ENTRIES BTB entries, each {valid, tag[TAG_W], target[ADDR_W]}.
- GHR[GHR_W], present only when MODE=1.
- br_cnt and mp_cnt.
REQ-007 Index rules:
- bidx = pcF[IDX_W+1:2] indexes the BTB.
- predidxF = bidx when MODE=0.
- predidxF = bidx XOR zero-extended GHR when MODE=1.
REQ-008 predtakenF SHALL be 1 iff btb[bidx].valid, btb[bidx].tag == pcF[ADDR_W-1:IDX_W+2], and cnt[predidxF][1] are all 1.
REQ-009 predtargetF SHALL be btb[bidx].target when predtakenF=1, and pcF+4 otherwise.
REQ-010 Fetch outputs SHALL be combinational from pcF and current state (zero latency).
REQ-011 A fetch read of an entry being written in the same cycle SHALL return the pre-update value.
REQ-012 On upd_valid=1 with upd_jump=0: cnt[upd_idx] SHALL increment when upd_taken=1 and decrement when upd_taken=0, saturating at 3 and 0.
REQ-013 On upd_valid=1 with upd_jump=1: cnt[upd_idx] SHALL be set to 3.
REQ-014 On upd_valid=1 with upd_taken=1: the BTB entry at upd_pc[IDX_W+1:2] SHALL be written {1, upd_pc tag, upd_target}, replacing any prior tag.
REQ-015 A not-taken update SHALL NOT modify the BTB.
REQ-016 When MODE=1, on upd_valid=1 the GHR SHALL be updated to {GHR[GHR_W-2:0], upd_taken} (non-speculative).
REQ-017 mispredictE SHALL be 1 iff upd_valid=1 and either:
- upd_taken != upd_predtaken, or
- upd_taken=1 and upd_target != upd_predtarget.
mispredictE is combinational.
REQ-018 redirect_pc SHALL be upd_target when upd_taken=1, and upd_pc+4 otherwise.
REQ-019 Counter rules:
- br_cnt increments on every upd_valid.
- mp_cnt increments on every mispredictE.
- Both wrap modulo 2^32.
- Both are unaffected by clear.
REQ-020 clear=1 SHALL, at the next edge:
- set all BTB valid bits to 0,
- set all cnt[] to 01,
- set GHR to 0.
clear SHALL take priority over a simultaneous update, and that update's table effects are discarded. br_cnt and mp_cnt still count it.
REQ-021 PC arithmetic SHALL be ADDR_W bits, with wrap-around on pc+4 at the top of the address space.
REQ-022 Bits pcF[1:0] and upd_pc[1:0] SHALL be ignored.

Reset
REQ-023 While reset=0, asynchronously:
- all valid bits = 0,
- all cnt[] = 01 (weakly not-taken),
- GHR = 0,
- br_cnt = mp_cnt = 0.
REQ-024 After reset, predtakenF=0 and predtargetF=pcF+4 for every pcF.
REQ-025 Reset asserted mid-operation SHALL override any concurrent update or clear.

Verification
REQ-026 Reset, pcF=0x100 -> predtakenF=0, predtargetF=0x104, br_cnt=0.
REQ-027 MODE=0; two taken updates, upd_pc=0x100, upd_target=0x80, upd_predtaken=0:
- first update -> mispredictE=1, redirect_pc=0x80;
- then pcF=0x100 -> predtakenF=1, predtargetF=0x80, mp_cnt=2, br_cnt=2.
REQ-028 From cnt=3 at pc 0x100; one not-taken update -> predtakenF still 1; a second -> predtakenF=0; a further not-taken update leaves cnt saturated at 0.
REQ-029 Aliasing, ENTRIES=16: BTB holds 0x100 -> 0x80; taken update 0x140 -> 0xC0 -> pcF=0x100 gives predtakenF=0 (tag miss), pcF=0x140 gives predtargetF=0xC0.
REQ-030 MODE=1, GHR_W=4; updates taken, taken, not-taken -> GHR=0110; pcF=0x100 -> predidxF=0x0 XOR 0x6 = 0x6.
REQ-031 Simultaneous events:
- clear=1 with a taken update at 0x100 -> the next cycle predicts not-taken, br_cnt increments;
- reset pulse during updates -> all state returns to REQ-023 values.
